// File: rtl/load_store_unit_if.sv
// Purpose : datapath-request and data-memory-bus signal bundle of the load/store unit.
// Latency : wiring only, no storage.
// Backpressure: req_valid is held by the requester until done; the memory side completes with bus_ack.
// Ports   : master = datapath + memory model (drives request, ack, read word);
//           slave  = load_store_unit (drives ready/stall/done/fault/rdata and the bus request).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        fault;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output req_valid, mem_write, funct3, addr, wdata, bus_ack, bus_rdata,
    input  req_ready, rdata, done, fault, stall,
           bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );

  modport slave (
    input  req_valid, mem_write, funct3, addr, wdata, bus_ack, bus_rdata,
    output req_ready, rdata, done, fault, stall,
           bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );
endinterface

// File: rtl/load_store_unit.sv
// Purpose : RV32I load/store unit: byte enables, store-lane replication, load align/extend, misalign faults.
// Latency : accept in cycle 0, bus_req from cycle 1; bus_ack in cycle N gives done in N+1; faults done in cycle 1.
// Backpressure: stall holds PC/writeback while an op is accepted or on the bus; BUS waits for bus_ack.
// Ports   : clk, reset (async, active low), lsu (load_store_unit_if.slave).
// Option  : define LSU_TIMEOUT_EN to abort a BUS phase after TIMEOUT_CYCLES cycles without bus_ack.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  lsu
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        fault_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  be_q;

  // The abort counter is 8 bits wide, so only 1..256 cycles are representable.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout_cfg
    $error("load_store_unit: TIMEOUT_CYCLES must be in 1..256");
  end

  // Request decode, evaluated combinationally while IDLE.
  logic        dec_illegal;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;

  always_comb begin
    dec_illegal = 1'b0;
    dec_be      = 4'b0000;
    dec_wdata   = lsu.wdata;
    case (lsu.funct3[1:0])
      2'b00: begin
        dec_be    = 4'b0001 << lsu.addr[1:0];
        dec_wdata = {4{lsu.wdata[7:0]}};
      end
      2'b01: begin
        dec_be      = 4'b0011 << lsu.addr[1:0];
        dec_wdata   = {2{lsu.wdata[15:0]}};
        dec_illegal = lsu.addr[0];
      end
      2'b10: begin
        dec_be      = 4'b1111;
        dec_illegal = |lsu.addr[1:0];
      end
      default: dec_illegal = 1'b1;
    endcase
    // Unsigned variants exist only for LB/LH; stores have no funct3[2] forms.
    if (lsu.funct3[2] && (lsu.mem_write || lsu.funct3[1]))
      dec_illegal = 1'b1;
  end

  // Load alignment and extension from the latched op.
  logic [31:0] shifted;
  logic [31:0] load_val;

  always_comb begin
    shifted = lsu.bus_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  logic timeout;

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt_q;

  // Held at zero outside BUS, so every BUS phase starts counting from 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                to_cnt_q <= 8'd0;
    else if (state_q != BUS)   to_cnt_q <= 8'd0;
    else                       to_cnt_q <= to_cnt_q + 8'd1;
  end

  assign timeout = (state_q == BUS) && (to_cnt_q == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (lsu.req_valid) state_d = dec_illegal ? RESP : BUS;
      BUS:     if (lsu.bus_ack || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      fault_q     <= 1'b0;
      we_q        <= 1'b0;
      rdata_q     <= 32'd0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      be_q        <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && lsu.req_valid) begin
        f3_q    <= lsu.funct3;
        off_q   <= lsu.addr[1:0];
        fault_q <= dec_illegal;
        // Faulted ops leave the bus registers untouched: no transaction follows.
        if (!dec_illegal) begin
          we_q        <= lsu.mem_write;
          bus_addr_q  <= {lsu.addr[31:2], 2'b00};
          bus_wdata_q <= dec_wdata;
          be_q        <= dec_be;
        end
      end
      if (state_q == BUS) begin
        if (lsu.bus_ack) begin
          if (!we_q) rdata_q <= load_val;
        end else if (timeout) begin
          fault_q <= 1'b1;
        end
      end
    end
  end

  assign lsu.req_ready = (state_q == IDLE);
  assign lsu.done      = (state_q == RESP);
  assign lsu.fault     = (state_q == RESP) && fault_q;
  // Low in RESP so the datapath commits in the done cycle.
  assign lsu.stall     = ((state_q == IDLE) && lsu.req_valid) || (state_q == BUS);
  assign lsu.bus_req   = (state_q == BUS);
  assign lsu.bus_we    = we_q;
  assign lsu.bus_addr  = bus_addr_q;
  assign lsu.bus_wdata = bus_wdata_q;
  assign lsu.bus_be    = be_q;
  assign lsu.rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : random and directed load/store ops against a byte-level memory and reference model.
// Latency : checks done cycle = ack delay + 1 (or 1 for faults), bus fields stable while waiting.
// Backpressure: memory model acks after a chosen number of BUS cycles; req_valid held until done.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if lsu_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .lsu   (lsu_bus.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Word-addressed memory, filled with random words on first touch.
  logic [31:0] mem [int unsigned];
  logic [31:0] exp_rdata;

  function automatic logic [31:0] rd_word(input logic [31:0] wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  // Reference: access size from funct3, lanes and extension by arithmetic.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word,
                       output logic legal, output logic [3:0] be,
                       output logic [31:0] bw, output logic [31:0] lv);
    int     size;
    int     off;
    longint v;
    size  = 1 << f3[1:0];
    off   = a % 4;
    legal = (f3[1:0] != 2'b11) && (we ? !f3[2] : (f3 != 3'b110)) && ((a % size) == 0);
    be    = 4'(((1 << size) - 1) << off);
    if (size == 1)      bw = {24'd0, wd[7:0]} * 32'h0101_0101;
    else if (size == 2) bw = {16'd0, wd[15:0]} * 32'h0001_0001;
    else                bw = wd;
    v = (longint'(word) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
    if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
      v = v - (longint'(1) << (8 * size));
    lv = 32'(v);
  endtask

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int delay);
    logic        legal;
    logic [3:0]  be;
    logic [31:0] bw, lv, word, tmp;
    logic [31:0] wa;
    int          nb;
    logic        fin;
    wa   = {a[31:2], 2'b00};
    word = rd_word(wa);
    model(we, f3, a, wd, word, legal, be, bw, lv);
    @(negedge clk);
    lsu_bus.req_valid = 1'b1;
    lsu_bus.mem_write = we;
    lsu_bus.funct3    = f3;
    lsu_bus.addr      = a;
    lsu_bus.wdata     = wd;
    #1;
    chk("accept_ready", lsu_bus.req_ready, 1);
    chk("accept_stall", lsu_bus.stall, 1);
    nb  = 0;
    fin = 1'b0;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      @(posedge clk);
      #1;
      lsu_bus.bus_ack   = 1'b0;
      lsu_bus.bus_rdata = $urandom;
      if (lsu_bus.done) begin
        fin = 1'b1;
        chk("done_cycle", cyc, legal ? (delay == 0 ? TO + 1 : delay + 1) : 1);
        chk("fault", lsu_bus.fault, (!legal || delay == 0) ? 1 : 0);
        if (legal && !we && delay != 0) exp_rdata = lv;
        chk("rdata", lsu_bus.rdata, exp_rdata);
        chk("resp_stall", lsu_bus.stall, 0);
        chk("bus_cycles", nb, legal ? (delay == 0 ? TO : delay) : 0);
        lsu_bus.req_valid = 1'b0;
      end else begin
        chk("wait_stall", lsu_bus.stall, 1);
        if (lsu_bus.bus_req) begin
          nb++;
          chk("bus_addr", lsu_bus.bus_addr, wa);
          chk("bus_be", lsu_bus.bus_be, be);
          chk("bus_we", lsu_bus.bus_we, we);
          if (we) chk("bus_wdata", lsu_bus.bus_wdata, bw);
          if (nb == delay) begin
            lsu_bus.bus_ack   = 1'b1;
            lsu_bus.bus_rdata = word;
            if (we) begin
              tmp = mem[wa];
              for (int i = 0; i < 4; i++)
                if (lsu_bus.bus_be[i]) tmp[8*i +: 8] = lsu_bus.bus_wdata[8*i +: 8];
              mem[wa] = tmp;
            end
          end
        end
      end
    end
    chk("op_completed", fin, 1);
    lsu_bus.req_valid = 1'b0;
    lsu_bus.bus_ack   = 1'b0;
    @(posedge clk);
    #1;
    chk("done_one_cycle", lsu_bus.done, 0);
    chk("back_idle", lsu_bus.req_ready, 1);
  endtask

  task automatic stray_ack();
    @(negedge clk);
    lsu_bus.bus_ack = 1'b1;
    @(posedge clk);
    #1;
    lsu_bus.bus_ack = 1'b0;
    chk("stray_done", lsu_bus.done, 0);
    chk("stray_busreq", lsu_bus.bus_req, 0);
    chk("stray_ready", lsu_bus.req_ready, 1);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    lsu_bus.req_valid = 1'b1;
    lsu_bus.mem_write = 1'b0;
    lsu_bus.funct3    = 3'b010;
    lsu_bus.addr      = 32'h0000_0110;
    lsu_bus.wdata     = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_busreq_pre", lsu_bus.bus_req, 1);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("rst_busreq_drop", lsu_bus.bus_req, 0);
    chk("rst_idle", lsu_bus.req_ready, 1);
    chk("rst_no_done", lsu_bus.done, 0);
    exp_rdata = 32'd0;
    chk("rst_rdata", lsu_bus.rdata, exp_rdata);
    lsu_bus.req_valid = 1'b0;
    @(negedge clk);
    lsu_bus.bus_ack = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    lsu_bus.bus_ack = 1'b0;
    chk("late_ack_done", lsu_bus.done, 0);
    chk("late_ack_busreq", lsu_bus.bus_req, 0);
    chk("late_ack_idle", lsu_bus.req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lsu_bus.req_valid = 1'b0;
    lsu_bus.mem_write = 1'b0;
    lsu_bus.funct3    = 3'd0;
    lsu_bus.addr      = 32'd0;
    lsu_bus.wdata     = 32'd0;
    lsu_bus.bus_ack   = 1'b0;
    lsu_bus.bus_rdata = 32'd0;
    exp_rdata         = 32'd0;
    #12;
    chk("reset_rdata", lsu_bus.rdata, 0);
    chk("reset_done", lsu_bus.done, 0);
    chk("reset_fault", lsu_bus.fault, 0);
    chk("reset_busreq", lsu_bus.bus_req, 0);
    chk("reset_buswe", lsu_bus.bus_we, 0);
    chk("reset_busaddr", lsu_bus.bus_addr, 0);
    chk("reset_buswdata", lsu_bus.bus_wdata, 0);
    chk("reset_busbe", lsu_bus.bus_be, 0);
    chk("reset_ready", lsu_bus.req_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    mem[32'h100] = 32'hDEAD_BEEF;
    do_op(1'b0, 3'b010, 32'h100, 32'd0, 1);
    chk("lw_literal", lsu_bus.rdata, 32'hDEAD_BEEF);

    mem[32'h100] = 32'h80FF_FFFF;
    do_op(1'b0, 3'b000, 32'h103, 32'd0, 1);
    chk("lb_literal", lsu_bus.rdata, 32'hFFFF_FF80);
    do_op(1'b0, 3'b100, 32'h103, 32'd0, 2);
    chk("lbu_literal", lsu_bus.rdata, 32'h0000_0080);

    do_op(1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 1);
    chk("sh_rdata_hold", lsu_bus.rdata, 32'h0000_0080);
    do_op(1'b0, 3'b010, 32'h100, 32'd0, 3);
    chk("sh_readback", lsu_bus.rdata, 32'hABCD_FFFF);

    do_op(1'b0, 3'b010, 32'h101, 32'd0, 1);
    stray_ack();
    do_op(1'b0, 3'b010, 32'h104, 32'd0, 5);
    mid_reset();

`ifdef LSU_TIMEOUT_EN
    do_op(1'b0, 3'b010, 32'h108, 32'd0, 0);
`endif

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) stray_ack();
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'h100 + 32'($urandom_range(0, 63)), $urandom, $urandom_range(1, 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
